// File: rtl/tx_8b10b_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tx_8b10b_pkg
//  Purpose  : Shared constants and table lookups for the 8b/10b transmit path.
//             Symbols are written here in the conventional "abcdei fghj"
//             order with bit 'a' in bit 9. to_line_order() reverses them so
//             that bit 'a' sits in bit 0, which is the first bit on the line.
//  Contents : width_sel_e    - WIDTH_SEL encodings
//             K28_5_RDN/RDP  - comma idle symbols for RD- / RD+
//             enc_5b6b_rdn   - 5b/6b table, RD- column
//             enc_3b4b_rdn   - 3b/4b table, RD- column (P7 or A7 for y=7)
//             width_to_nbytes, to_line_order helpers
//  Revision : 1.0 - initial release
// ============================================================================
package tx_8b10b_pkg;

    typedef enum logic [1:0] {
        WSEL_8B   = 2'b00,
        WSEL_16B  = 2'b01,
        WSEL_32B  = 2'b10,
        WSEL_RSVD = 2'b11
    } width_sel_e;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    // The reserved code sends a full word, the same as the 32-bit code.
    function automatic logic [2:0] width_to_nbytes(input logic [1:0] sel);
        logic [2:0] n;
        n = 3'd4;
        case (width_sel_e'(sel))
            WSEL_8B:  n = 3'd1;
            WSEL_16B: n = 3'd2;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [9:0] to_line_order(input logic [9:0] w);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = w[9-i];
        end
        return r;
    endfunction

    function automatic logic [5:0] enc_5b6b_rdn(input logic [4:0] x);
        logic [5:0] c;
        c = 6'b000000;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] enc_3b4b_rdn(input logic [2:0] y, input logic alt7);
        logic [3:0] c;
        c = 4'b0000;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            default: c = alt7 ? 4'b0111 : 4'b1110;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_8b10b.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_8b10b
//  Purpose  : Combinational 8b/10b data encoder with running disparity.
//  Ports    : data   [7:0] in  - byte to encode (HGF EDCBA)
//             rd_in        in  - running disparity before the symbol (0=RD-)
//             sym    [9:0] out - symbol in line order, bit 0 = 'a' (sent first)
//             rd_out       out - running disparity after the symbol
//  Revision : 1.0 - initial release
// ============================================================================
module encoder_8b10b
    import tx_8b10b_pkg::*;
(
    input  logic [7:0] data,
    input  logic       rd_in,
    output logic [9:0] sym,
    output logic       rd_out
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] code6_n;
    logic [5:0] code6;
    logic [3:0] code4_n;
    logic [3:0] code4;
    logic       rd_mid;
    logic       alt7;

    always_comb begin
        x = data[4:0];
        y = data[7:5];

        // Unbalanced codes swap to their complement under RD+. D.7 is
        // balanced but still has a separate RD+ form.
        code6_n = enc_5b6b_rdn(x);
        if ((rd_in == RD_POS) && (($countones(code6_n) != 3) || (x == 5'd7))) begin
            code6 = ~code6_n;
        end else begin
            code6 = code6_n;
        end
        rd_mid = rd_in ^ ($countones(code6_n) != 3);

        // A7 avoids a run of five identical bits across the sub-block seam.
        alt7 = (y == 3'd7) &&
               (((rd_mid == RD_NEG) && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                ((rd_mid == RD_POS) && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

        code4_n = enc_3b4b_rdn(y, alt7);
        if ((rd_mid == RD_POS) && (($countones(code4_n) != 2) || (y == 3'd3))) begin
            code4 = ~code4_n;
        end else begin
            code4 = code4_n;
        end
        rd_out = rd_mid ^ ($countones(code4_n) != 2);

        sym = to_line_order({code6, code4});
    end

endmodule
`default_nettype wire

// File: rtl/tx_serializer_8b10b.sv
`default_nettype none
// ============================================================================
//  Module   : tx_serializer_8b10b
//  Purpose  : Transmit datapath. Accepts 8/16/32-bit words, slices them into
//             bytes, 8b/10b-encodes each byte and shifts the symbols out one
//             bit per clock. Sends K28.5 idles while no word is held.
//  Ports    : CLK            in  - bit clock
//             RESET_TX       in  - asynchronous active-low reset
//             WIDTH_SEL [1:0] in - 00=8b, 01=16b, 10/11=32b
//             IN_DATA  [31:0] in - parallel word, byte0=[7:0] sent first
//             IN_VALID       in  - word offered
//             IN_READY       out - word taken on the edge with VALID&READY
//             OUT_SERIAL     out - serial line, bit 'a' first
//             OUT_SYNC       out - first bit time of each symbol
//             OUT_K          out - current symbol is a K28.5 idle
//  Revision : 1.0 - initial release
// ============================================================================
module tx_serializer_8b10b
    import tx_8b10b_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_TX,
    input  logic [1:0]  WIDTH_SEL,
    input  logic [31:0] IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic        OUT_SERIAL,
    output logic        OUT_SYNC,
    output logic        OUT_K
);

    localparam logic [3:0] BIT_LAST = 4'd9;

    logic        hold_full;
    logic [31:0] hold_data;
    logic [2:0]  nbytes;
    logic [1:0]  byte_idx;
    logic [3:0]  bit_cnt;
    logic [9:0]  shreg;
    logic        rd;
    logic        k_flag;

    logic [7:0]  cur_byte;
    logic [9:0]  enc_sym;
    logic        enc_rd_out;
    logic        accept;
    logic        boundary;
    logic        last_byte;

    assign cur_byte  = hold_data[{byte_idx, 3'b000} +: 8];
    assign accept    = IN_VALID & IN_READY;
    assign boundary  = (bit_cnt == BIT_LAST);
    assign last_byte = ({1'b0, byte_idx} == (nbytes - 3'd1));

    encoder_8b10b u_encoder (
        .data   (cur_byte),
        .rd_in  (rd),
        .sym    (enc_sym),
        .rd_out (enc_rd_out)
    );

    always_ff @(posedge CLK or negedge RESET_TX) begin
        if (!RESET_TX) begin
            hold_full <= 1'b0;
            hold_data <= 32'd0;
            nbytes    <= 3'd1;
            byte_idx  <= 2'd0;
            bit_cnt   <= BIT_LAST;  // first edge out of reset loads a symbol
            shreg     <= 10'd0;
            rd        <= RD_NEG;
            k_flag    <= 1'b0;
        end else begin
            // Accept only happens with the hold register empty, so it never
            // collides with the boundary logic below that drains it.
            if (accept) begin
                hold_data <= IN_DATA;
                nbytes    <= width_to_nbytes(WIDTH_SEL);
                hold_full <= 1'b1;
                byte_idx  <= 2'd0;
            end

            if (boundary) begin
                bit_cnt <= 4'd0;
                if (hold_full) begin
                    shreg  <= enc_sym;
                    rd     <= enc_rd_out;
                    k_flag <= 1'b0;
                    if (last_byte) begin
                        hold_full <= 1'b0;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end else begin
                    // K28.5 is unbalanced in both forms, so disparity flips.
                    shreg  <= (rd == RD_POS) ? to_line_order(K28_5_RDP)
                                             : to_line_order(K28_5_RDN);
                    rd     <= ~rd;
                    k_flag <= 1'b1;
                end
            end else begin
                shreg   <= {1'b0, shreg[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    assign IN_READY   = RESET_TX & ~hold_full;
    assign OUT_SERIAL = shreg[0];
    assign OUT_SYNC   = (bit_cnt == 4'd0);
    assign OUT_K      = k_flag;

endmodule
`default_nettype wire

// File: tb/tb_tx_serializer_8b10b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_serializer_8b10b
//  Purpose  : Self-checking bench for tx_serializer_8b10b. A symbol-level
//             reference model (byte queue plus explicit RD-/RD+ code tables)
//             predicts every output bit; directed and random words drive it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_serializer_8b10b;

    logic        CLK = 1'b0;
    logic        RESET_TX = 1'b1;
    logic [1:0]  WIDTH_SEL = 2'b00;
    logic [31:0] IN_DATA = 32'd0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        OUT_SERIAL;
    logic        OUT_SYNC;
    logic        OUT_K;

    int num_checks = 0;
    int num_fail   = 0;

    always #5 CLK = ~CLK;

    tx_serializer_8b10b dut (
        .CLK        (CLK),
        .RESET_TX   (RESET_TX),
        .WIDTH_SEL  (WIDTH_SEL),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .OUT_SERIAL (OUT_SERIAL),
        .OUT_SYNC   (OUT_SYNC),
        .OUT_K      (OUT_K)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Code tables, written abcdei / fghj with 'a' as the MSB.
    logic [5:0] c6_n [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] c6_p [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] c4_n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] c4_p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};

    function automatic logic [9:0] ref_encode(input logic [7:0] b, input logic rd_in,
                                              output logic rd_after);
        int x;
        int y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic r;
        logic alt;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        s6 = rd_in ? c6_p[x] : c6_n[x];
        r = rd_in ^ ($countones(s6) != 3);
        alt = (y == 7) && (r ? (x == 11 || x == 13 || x == 14) : (x == 17 || x == 18 || x == 20));
        if (alt) s4 = r ? 4'b1000 : 4'b0111;
        else     s4 = r ? c4_p[y] : c4_n[y];
        rd_after = r ^ ($countones(s4) != 2);
        return {s6, s4};
    endfunction

    // Reference model state.
    int         m_pos = 9;
    logic [9:0] m_w = 10'd0;
    logic       m_k = 1'b0;
    logic       m_rd = 1'b0;
    logic       m_rd_in = 1'b0;
    logic       m_live = 1'b0;
    logic [7:0] m_byte = 8'd0;
    logic       m_acc = 1'b0;
    logic [7:0] m_held [$];
    logic [9:0] line_hist = 10'd0;

    always @(posedge CLK) begin
        logic nr;
        int   n;
        if (!RESET_TX) begin
            m_pos = 9; m_w = 10'd0; m_k = 1'b0; m_rd = 1'b0;
            m_live = 1'b0; m_acc = 1'b0;
            m_held.delete();
        end else begin
            m_acc = IN_VALID && (m_held.size() == 0);
            if (m_pos == 9) begin
                m_pos = 0;
                m_live = 1'b1;
                m_rd_in = m_rd;
                if (m_held.size() > 0) begin
                    m_byte = m_held.pop_front();
                    m_w = ref_encode(m_byte, m_rd, nr);
                    m_rd = nr;
                    m_k = 1'b0;
                end else begin
                    m_w = m_rd ? 10'b1100000101 : 10'b0011111010;
                    m_rd = ~m_rd;
                    m_k = 1'b1;
                end
            end else begin
                m_pos++;
            end
            if (m_acc) begin
                n = (WIDTH_SEL == 2'b00) ? 1 : (WIDTH_SEL == 2'b01) ? 2 : 4;
                for (int i = 0; i < n; i++) m_held.push_back(IN_DATA[8*i +: 8]);
            end
        end
        #2;
        check_val("ready", 32'(IN_READY), 32'(RESET_TX && (m_held.size() == 0)));
        check_val("serial", 32'(OUT_SERIAL), 32'(m_w[9 - m_pos]));
        check_val("sync", 32'(OUT_SYNC), 32'(m_pos == 0));
        check_val("k_flag", 32'(OUT_K), 32'(m_k));
        line_hist = {line_hist[8:0], OUT_SERIAL};
        if (m_live && (m_pos == 9)) begin
            if (m_k)
                check_val("k28_5_sym", 32'(line_hist), 32'(m_rd_in ? 10'b1100000101 : 10'b0011111010));
            else if (m_byte == 8'h00 && !m_rd_in)
                check_val("d0_0_rdn", 32'(line_hist), 32'(10'b1001110100));
            else if (m_byte == 8'hF1 && !m_rd_in)
                check_val("d17_7_a7", 32'(line_hist), 32'(10'b1000110111));
            else if (m_byte == 8'hEB && m_rd_in)
                check_val("d11_7_a7", 32'(line_hist), 32'(10'b1101001000));
            else if (m_byte == 8'hB5)
                check_val("d21_5", 32'(line_hist), 32'(10'b1010101010));
        end
    end

    task automatic send_word(input logic [1:0] ws, input logic [31:0] d, input bit keep_valid);
        bit got;
        got = 1'b0;
        @(negedge CLK);
        WIDTH_SEL = ws; IN_DATA = d; IN_VALID = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge CLK); #1;
            if (m_acc) got = 1'b1;
        end
        check_val("accept_timeout", 32'(got), 32'd1);
        // Scramble inputs after accept: the held word must not follow them.
        @(negedge CLK);
        IN_VALID = keep_valid;
        WIDTH_SEL = 2'($urandom_range(0, 3));
        IN_DATA = $urandom;
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 7))
            0: return 8'hF1;
            1: return 8'hEB;
            2: return 8'h00;
            3: return 8'hB5;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #1 RESET_TX = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_TX = 1'b1;
        repeat (40) @(negedge CLK);                   // idle K28.5 stream

        send_word(2'b10, 32'hB5B5B5B5, 1'b0); idle(50);
        send_word(2'b00, 32'h12345600, 1'b0); idle(25);
        send_word(2'b00, 32'h000000F1, 1'b0); idle(25);
        send_word(2'b10, 32'hEBC0EBC0, 1'b0); idle(50);
        send_word(2'b10, $urandom, 1'b1);             // back-to-back words
        send_word(2'b10, $urandom, 1'b0); idle(60);
        send_word(2'b11, 32'hA1B2C3D4, 1'b0); idle(50);
        send_word(2'b01, 32'h00F1F1EB, 1'b0); idle(30);

        // Reset in the middle of a word.
        send_word(2'b10, 32'hCAFEF00D, 1'b0);
        IN_VALID = 1'b0;
        repeat (18) @(negedge CLK);
        RESET_TX = 1'b0;
        #1;
        check_val("rst_serial", 32'(OUT_SERIAL), 32'd0);
        check_val("rst_ready", 32'(IN_READY), 32'd0);
        check_val("rst_sync", 32'(OUT_SYNC), 32'd0);
        check_val("rst_k", 32'(OUT_K), 32'd0);
        repeat (3) @(negedge CLK);
        RESET_TX = 1'b1;
        idle(40);

        for (int w = 0; w < 80; w++) begin
            logic [31:0] d;
            bit b2b;
            d = {pick_byte(), pick_byte(), pick_byte(), pick_byte()};
            b2b = ($urandom_range(0, 2) == 0);
            send_word(2'($urandom_range(0, 3)), d, b2b);
            if (!b2b) idle($urandom_range(0, 25));
        end
        idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", num_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
